// File: rtl/rtype_exec_ctrl.sv
// Multi-cycle fetch/decode/execute/writeback controller for RV32 R-type ALU instructions.
// Halts on ECALL (done) or on any non-R-type or unsupported encoding (illegal + done).
module rtype_exec_ctrl #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [4:0]  rf_rs1,
  output logic [4:0]  rf_rs2,
  output logic [4:0]  rf_rd,
  output logic        rf_we,
  output logic        ex_en,
  output logic [4:0]  alu_control,
  output logic        busy,
  output logic        done,
  output logic        illegal,
  output logic [31:0] retired_count
);

  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_SUB  = 5'd1;
  localparam logic [4:0] ALU_SLL  = 5'd2;
  localparam logic [4:0] ALU_SLT  = 5'd3;
  localparam logic [4:0] ALU_SLTU = 5'd4;
  localparam logic [4:0] ALU_XOR  = 5'd5;
  localparam logic [4:0] ALU_SRL  = 5'd6;
  localparam logic [4:0] ALU_SRA  = 5'd7;
  localparam logic [4:0] ALU_OR   = 5'd8;
  localparam logic [4:0] ALU_AND  = 5'd9;

  localparam logic [6:0]  OPC_RTYPE = 7'b0110011;
  localparam logic [31:0] INSN_ECALL = 32'h0000_0073;

  typedef enum logic [2:0] {
    StIdle, StFetch, StDecode, StExecute, StWriteback, StHalt
  } state_e;

  state_e      r_state, w_state_next;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_retired;
  logic        r_illegal;

  logic [6:0]  w_opcode;
  logic [2:0]  w_func3;
  logic [6:0]  w_func7;
  logic        w_alt;
  logic        w_ecall;
  logic        w_legal;

  assign w_opcode = r_instr[6:0];
  assign w_func3  = r_instr[14:12];
  assign w_func7  = r_instr[31:25];
  assign w_alt    = (w_func7 == 7'h20);
  assign w_ecall  = (r_instr == INSN_ECALL);
  assign w_legal  = (w_opcode == OPC_RTYPE) &&
                    ((w_func7 == 7'h00) ||
                     (w_alt && ((w_func3 == 3'b000) || (w_func3 == 3'b101))));

  always_comb begin
    alu_control = ALU_ADD;
    unique case (w_func3)
      3'b000: alu_control = w_alt ? ALU_SUB : ALU_ADD;
      3'b001: alu_control = ALU_SLL;
      3'b010: alu_control = ALU_SLT;
      3'b011: alu_control = ALU_SLTU;
      3'b100: alu_control = ALU_XOR;
      3'b101: alu_control = w_alt ? ALU_SRA : ALU_SRL;
      3'b110: alu_control = ALU_OR;
      3'b111: alu_control = ALU_AND;
      default: alu_control = ALU_ADD;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:      if (start) w_state_next = StFetch;
      StFetch:     if (imem_ready) w_state_next = StDecode;
      StDecode: begin
        if (w_ecall || !w_legal) w_state_next = StHalt;
        else                     w_state_next = StExecute;
      end
      StExecute:   w_state_next = StWriteback;
      StWriteback: w_state_next = StFetch;
      StHalt:      if (start) w_state_next = StFetch;
      default:     w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= StIdle;
    else          r_state <= w_state_next;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pc      <= PC_RESET;
      r_instr   <= '0;
      r_retired <= '0;
      r_illegal <= 1'b0;
    end else begin
      unique case (r_state)
        StFetch: if (imem_ready) r_instr <= imem_rdata;
        StDecode: if (!w_ecall && !w_legal) r_illegal <= 1'b1;
        StWriteback: begin
          r_pc      <= r_pc + PC_STEP;
          r_retired <= r_retired + 32'd1;
        end
        StHalt: begin
          if (start) begin
            r_pc      <= PC_RESET;
            r_illegal <= 1'b0;
            r_retired <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Status and strobes decode straight from state so reset clears them without a clock.
  assign imem_req      = (r_state == StFetch);
  assign imem_addr     = r_pc;
  assign ex_en         = (r_state == StExecute);
  assign rf_we         = (r_state == StWriteback) && (rf_rd != 5'd0);
  assign busy          = (r_state == StFetch) || (r_state == StDecode) ||
                         (r_state == StExecute) || (r_state == StWriteback);
  assign done          = (r_state == StHalt);
  assign illegal       = r_illegal;
  assign retired_count = r_retired;
  assign rf_rs1        = r_instr[19:15];
  assign rf_rs2        = r_instr[24:20];
  assign rf_rd         = r_instr[11:7];

endmodule
